bit_serial_adder_cum_subtractor: RTL and testbench

Bit-serial, handshaked responder for the adder-cum-subtractor operand interface: accepts operands `a`, `b` and operation select `cbin` on a start strobe, computes `a+b` or `a-b` one bit per clock, LSB first, and returns `sd`/`cbout` with a one-cycle `done` pulse. It is the low-area sequential counterpart of the combinational 4-bit adder-cum-subtractor. It sits behind any operand issuer (bench or controller) that drives the same `a`/`b`/`cbin` → `sd`/`cbout` interface.

---
 rtl/bit_serial_adder_cum_subtractor.sv | 148 ++++++++++++++
 tb/tb_bit_serial_adder_cum_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder_cum_subtractor.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with a
// start/busy/done handshake. sd = a + (b ^ {WIDTH{cbin}}) + cbin.
// Optional build macro ADDSUB_OVF_EN adds a registered signed-overflow output ovf.
module bit_serial_adder_cum_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cbin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sd,
   output logic             cbout
`ifdef ADDSUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] rs_q, rs_d;
   logic             c_q, c_d;
   logic             m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic             cbout_q, cbout_d;
   logic             bit_b;
   logic             bit_sum;
   logic             bit_cout;
`ifdef ADDSUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // State and datapath registers; synchronous reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rs_q    <= '0;
         c_q     <= 1'b0;
         m_q     <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sd_q    <= '0;
         cbout_q <= 1'b0;
`ifdef ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rs_q    <= rs_d;
         c_q     <= c_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sd_q    <= sd_d;
         cbout_q <= cbout_d;
`ifdef ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Next-state logic: operand latch in IDLE, one full-adder bit per RUN cycle
   always_comb begin
      state_d  = state_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rs_d     = rs_q;
      c_d      = c_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sd_d     = sd_q;
      cbout_d  = cbout_q;
`ifdef ADDSUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      bit_b    = rb_q[0] ^ m_q;
      bit_sum  = ra_q[0] ^ bit_b ^ c_q;
      bit_cout = (ra_q[0] & bit_b) | (ra_q[0] & c_q) | (bit_b & c_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               m_d     = cbin;
               c_d     = cbin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            ra_d  = {1'b0, ra_q[WIDTH-1:1]};
            rb_d  = {1'b0, rb_q[WIDTH-1:1]};
            rs_d  = {bit_sum, rs_q[WIDTH-1:1]};
            c_d   = bit_cout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sd_d    = {bit_sum, rs_q[WIDTH-1:1]};
               cbout_d = bit_cout;
`ifdef ADDSUB_OVF_EN
               // carry into MSB (c_q) vs carry out of MSB
               ovf_d   = c_q ^ bit_cout;
`endif
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sd    = sd_q;
   assign cbout = cbout_q;
`ifdef ADDSUB_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder_cum_subtractor.sv
// Scoreboard bench for bit_serial_adder_cum_subtractor (WIDTH=4).
module tb_bit_serial_adder_cum_subtractor;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cbin;
   logic         busy;
   logic         done;
   logic [W-1:0] sd;
   logic         cbout;
`ifdef ADDSUB_OVF_EN
   logic         ovf;
`endif

   bit_serial_adder_cum_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cbin  (cbin),
      .busy  (busy),
      .done  (done),
      .sd    (sd),
      .cbout (cbout)
`ifdef ADDSUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sd;
      logic         cbout;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      if (done) begin
         check("done_not_consecutive", 32'(prev_done), 32'(0));
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(1), 32'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sd", 32'(sd), 32'(e.sd));
            check("cbout", 32'(cbout), 32'(e.cbout));
`ifdef ADDSUB_OVF_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            check("latency", 32'(cyc), 32'(e.cyc));
            check("busy_at_done", 32'(busy), 32'(0));
         end
      end
      prev_done <= done;
   end

   // Wait (bounded) for the block to be idle, then issue one operation
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic push, input logic [W-1:0] esd, input logic ecb,
                        input logic eovf);
      int guard = 0;
      while (busy && guard < 4 * W + 10) begin
         @(negedge clk);
         guard++;
      end
      if (busy) check("idle_timeout", 32'(1), 32'(0));
      a = ia; b = ib; cbin = ic; start = 1'b1;
      if (push) begin
         exp_t e;
         e.sd = esd; e.cbout = ecb; e.ovf = eovf; e.cyc = cyc + 1 + W;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) until all expected results have been seen
   task automatic drain();
      int guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 8 * W + 20) begin
         @(negedge clk);
         guard++;
      end
      check("drain_timeout", 32'(exp_q.size()), 32'(0));
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc);
      logic [W:0]   full;
      logic [W-1:0] bb;
      logic         ov;
      bb   = mb ^ {W{mc}};
      full = {1'b0, ma} + {1'b0, bb} + (W+1)'(mc);
      ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
      return {ov, full};
   endfunction

   initial begin
      logic [W+1:0] r;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cbin = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_sd", 32'(sd), 32'(0));
      check("rst_cbout", 32'(cbout), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy), 32'(0));
         check("idle_sd", 32'(sd), 32'(0));
      end

      // Directed add / subtract vectors
      issue(4'b0000, 4'b0101, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b0);
      issue(4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0);
      issue(4'b0110, 4'b0101, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0);
      issue(4'b0101, 4'b0110, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0);
      issue(4'b0111, 4'b1000, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b1);
      // start issued in the done cycle of the previous op
      issue(4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0);
      drain();

      // start mid-RUN with new operands must be ignored
      issue(4'b0011, 4'b0001, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
      a = 4'b1111; b = 4'b1111; cbin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset in RUN cycle 2 aborts the operation
      issue(4'b1010, 4'b0011, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'(0));
      check("abort_done", 32'(done), 32'(0));
      check("abort_sd", 32'(sd), 32'(0));
      check("abort_cbout", 32'(cbout), 32'(0));
      for (int i = 0; i < 6; i++) @(negedge clk);
      issue(4'b1010, 4'b0011, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
      drain();

      // All operand/mode combinations back-to-back
      for (int ic = 0; ic < 2; ic++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               r = model(W'(ia), W'(ib), 1'(ic));
               issue(W'(ia), W'(ib), 1'(ic), 1'b1, r[W-1:0], r[W], r[W+1]);
            end
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
